// File: rtl/smem_pkg.sv
// Shared definitions for the shared-memory bank scheduler: sizes, FSM encoding
// and address field helper.
package smem_pkg;

  localparam int unsigned NUM_CORES = 16;
  localparam int unsigned ADDR_W    = 12;
  localparam int unsigned DATA_W    = 8;
  localparam int unsigned BANK_BITS = 4;
  localparam int unsigned ROW_W     = ADDR_W - BANK_BITS;
  localparam int unsigned CNT_W     = 16;
  localparam int unsigned ID_W      = $clog2(NUM_CORES);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  // Low bits select the bank, the remaining high bits are the SRAM row.
  typedef struct packed {
    logic [ROW_W-1:0]     row;
    logic [BANK_BITS-1:0] bank;
  } addr_fields_t;

  function automatic addr_fields_t split_addr(input logic [ADDR_W-1:0] addr);
    return addr_fields_t'(addr);
  endfunction

endpackage

// File: rtl/rr_pick16.sv
// Combinational round-robin priority encoder: first set bit at or after ptr_i,
// wrapping from the top index back to 0.
module rr_pick16
  import smem_pkg::*;
(
  input  logic [NUM_CORES-1:0] elig_i,
  input  logic [ID_W-1:0]      ptr_i,
  output logic                 valid_c_o,
  output logic [ID_W-1:0]      idx_c_o
);

  logic [ID_W-1:0] cand;

  // Scan from farthest to nearest so the closest hit to ptr_i is written last.
  always_comb begin
    valid_c_o = 1'b0;
    idx_c_o   = '0;
    cand      = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      cand = ptr_i + ID_W'(i);
      if (elig_i[cand]) begin
        valid_c_o = 1'b1;
        idx_c_o   = cand;
      end
    end
  end

endmodule

// File: rtl/smem_bank_scheduler.sv
// Per-bank scheduler: filters core requests for this bank, grants one in
// round-robin order, runs a single SRAM access and pulses finish to the winner.
module smem_bank_scheduler
  import smem_pkg::*;
(
  input  logic                        clock,
  input  logic                        reset,
  input  logic [BANK_BITS-1:0]        bank_n,
  input  logic [NUM_CORES-1:0]        read,
  input  logic [NUM_CORES-1:0]        write,
  input  logic [NUM_CORES*ADDR_W-1:0] addr_in,
  input  logic [NUM_CORES*DATA_W-1:0] data_in,
  output logic                        mem_en,
  output logic                        mem_we,
  output logic [ROW_W-1:0]            mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic [DATA_W-1:0]           mem_rdata,
  output logic [NUM_CORES-1:0]        finish,
  output logic [DATA_W-1:0]           data_out,
  output logic                        busy,
  output logic [CNT_W-1:0]            conflict_cnt
);

  state_e                state_q, state_d;
  logic [ID_W-1:0]       id_q, id_d;
  logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic                  mask_v_q, mask_v_d;
  logic [ID_W-1:0]       mask_id_q, mask_id_d;
  logic                  mem_en_q, mem_en_d;
  logic                  mem_we_q, mem_we_d;
  logic [ROW_W-1:0]      mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]     mem_wdata_q, mem_wdata_d;
  logic [NUM_CORES-1:0]  finish_q, finish_d;
  logic                  rd_resp_q, rd_resp_d;
  logic                  busy_q, busy_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic [ADDR_W-1:0]     addr_a [NUM_CORES];
  logic [DATA_W-1:0]     wdata_a [NUM_CORES];
  addr_fields_t          fld_c [NUM_CORES];
  logic [NUM_CORES-1:0]  elig_c;
  logic                  multi_c;
  logic                  pick_valid_c;
  logic [ID_W-1:0]       pick_idx_c;

  // Unpack the core buses and decide per-core eligibility for this bank.
  for (genvar k = 0; k < NUM_CORES; k++) begin : g_core
    assign addr_a[k]  = addr_in[k*ADDR_W +: ADDR_W];
    assign wdata_a[k] = data_in[k*DATA_W +: DATA_W];
    assign fld_c[k]   = split_addr(addr_a[k]);
    assign elig_c[k]  = (read[k] | write[k]) && (fld_c[k].bank == bank_n) &&
                        !(mask_v_q && (mask_id_q == ID_W'(k)));
  end

  assign multi_c = (elig_c & (elig_c - NUM_CORES'(1))) != '0;

  rr_pick16 u_pick (
    .elig_i    (elig_c),
    .ptr_i     (rr_ptr_q),
    .valid_c_o (pick_valid_c),
    .idx_c_o   (pick_idx_c)
  );

  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    rr_ptr_d    = rr_ptr_q;
    mask_v_d    = mask_v_q;
    mask_id_d   = mask_id_q;
    mem_en_d    = 1'b0;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    finish_d    = '0;
    rd_resp_d   = 1'b0;
    cnt_d       = cnt_q;

    if (multi_c && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        mask_v_d = 1'b0;
        if (pick_valid_c) begin
          state_d     = ST_GRANT;
          id_d        = pick_idx_c;
          mem_en_d    = 1'b1;
          mem_we_d    = write[pick_idx_c];
          mem_addr_d  = fld_c[pick_idx_c].row;
          mem_wdata_d = wdata_a[pick_idx_c];
        end
      end
      ST_GRANT: begin
        state_d   = ST_RESP;
        finish_d  = NUM_CORES'(1) << id_q;
        rd_resp_d = !mem_we_q;
      end
      ST_RESP: begin
        state_d   = ST_IDLE;
        rr_ptr_d  = id_q + ID_W'(1);
        mask_v_d  = 1'b1;
        mask_id_d = id_q;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      id_q        <= '0;
      rr_ptr_q    <= '0;
      mask_v_q    <= 1'b0;
      mask_id_q   <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      finish_q    <= '0;
      rd_resp_q   <= 1'b0;
      busy_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      id_q        <= id_d;
      rr_ptr_q    <= rr_ptr_d;
      mask_v_q    <= mask_v_d;
      mask_id_q   <= mask_id_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      finish_q    <= finish_d;
      rd_resp_q   <= rd_resp_d;
      busy_q      <= busy_d;
      cnt_q       <= cnt_d;
    end
  end

  assign mem_en       = mem_en_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign finish       = finish_q;
  assign busy         = busy_q;
  assign conflict_cnt = cnt_q;
  // SRAM output is already a flop; a registered select steers it to the core.
  assign data_out     = rd_resp_q ? mem_rdata : '0;

endmodule

// File: doc/smem_bank_scheduler.md
Name: smem_bank_scheduler

Overview:
- Per-bank request scheduler for the 16-core shared memory.
- Each cycle it filters the 16 core requests down to those whose address targets this bank, then grants one of them in round-robin order.
- It drives the bank's single-port SRAM and returns a one-cycle finish pulse, with read data, to the granted core.
- One instance per bank; it sits between the core-side read/write/address/data buses and the bank SRAM macro.

Parameters:
- NUM_CORES, 16, number of requesters.
- ADDR_W, 12, core address width.
- DATA_W, 8, data width.
- BANK_BITS, 4, low address bits that select the bank.
- ROW_W, 8, SRAM row address width (ADDR_W-BANK_BITS).
- CNT_W, 16, width of the conflict statistics counter.

Ports:
- clock  in  1  system clock; one clock domain, all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- bank_n  in  BANK_BITS  static bank index for this instance.
- read  in  NUM_CORES  per-core read request; held until that core's finish.
- write  in  NUM_CORES  per-core write request; held until that core's finish.
- addr_in  in  NUM_CORES*ADDR_W  packed addresses; core k at [k*12 +: 12].
- data_in  in  NUM_CORES*DATA_W  packed write data; core k at [k*8 +: 8].
- mem_en  out  1  SRAM access strobe.
- mem_we  out  1  SRAM write enable; valid when mem_en=1.
- mem_addr  out  ROW_W  SRAM row, taken from addr[11:4].
- mem_wdata  out  DATA_W  SRAM write data.
- mem_rdata  in  DATA_W  SRAM read data; valid the cycle after mem_en with mem_we=0.
- finish  out  NUM_CORES  one-hot, one-cycle completion pulse.
- data_out  out  DATA_W  read data; valid when any finish bit is high.
- busy  out  1  high in GRANT or RESP.
- conflict_cnt  out  CNT_W  saturating count of cycles with two or more eligible requesters.

Behaviour:
- Eligibility: core k is eligible when all of the following hold:
  - (read[k] | write[k]) = 1;
  - addr_in[k][3:0] == bank_n;
  - k != mask_id, or mask_v = 0.
- Read and write both high on one core: treated as a write.
- States:
  - IDLE: if any core is eligible, grant the first eligible core at or after rr_ptr (wrapping 15->0). Latch its id, we, row and wdata, then go to GRANT. Otherwise stay in IDLE.
  - GRANT: mem_en=1 for exactly one cycle, with mem_we, mem_addr and mem_wdata driven from the latched values. Go to RESP.
  - RESP: finish[id]=1; data_out = mem_rdata for a read, 0 for a write. Update rr_ptr = id+1 (mod 16). Set mask_v=1 and mask_id=id. Go to IDLE.
- Mask: mask_v is cleared after one cycle in IDLE. This stops a core that is still holding its request in the cycle after finish from being re-granted.
- Latency: request seen in IDLE at cycle t -> mem_en at t+1 -> finish at t+2. Peak throughput is one access every 3 cycles per bank.
- Requests that change while the block is in GRANT or RESP are ignored; the latched values are used.
- A requester dropping its request mid-transaction does not abort it; finish still pulses.
- conflict_cnt:
  - increments in any cycle with two or more eligible cores, evaluated in every state;
  - saturates at all-ones.
- Reset values (applied synchronously; overrides any in-flight transaction with no finish issued):
  - state = IDLE, rr_ptr = 0, mask_v = 0;
  - mem_en, mem_we, mem_addr, mem_wdata = 0;
  - finish = 0, data_out = 0, busy = 0, conflict_cnt = 0.
- All outputs are registered.

Decomposition:
- Shared package smem_pkg holds:
  - NUM_CORES, ADDR_W, DATA_W, BANK_BITS, ROW_W;
  - the state encoding (IDLE=2'd0, GRANT=2'd1, RESP=2'd2);
  - a function extracting the bank and row fields from an address.
- One sub-module, rr_pick16: combinational round-robin priority encoder.
  - Inputs: 16-bit eligible vector and 4-bit pointer.
  - Outputs: valid and 4-bit index.

Test Plan:
- Single read: bank_n=3; core 5 read, addr 12'h0A3; SRAM row 0x0A holds 0x5C -> mem_en at t+1 with mem_addr=0x0A and mem_we=0; finish[5] and data_out=0x5C at t+2; no re-grant at t+3.
- Single write: core 0 write, addr 12'h013, data 0xA7, bank 3 -> mem_we=1, mem_addr=0x01, mem_wdata=0xA7; finish[0]=1 with data_out=0; a later read from core 9 of the same address returns 0xA7.
- Round-robin: cores 2, 7 and 15 hold requests to bank 3 -> grant order 2, 7, 15, with finish pulses 3 cycles apart; conflict_cnt = number of cycles with two or more eligible cores (expected 6).
- Wrap and filter: rr_ptr=14; cores 1 and 14 target bank 3, core 15 targets bank 4 -> order 14 then 1; core 15 is never granted.
- Read and write together: core 4 asserts both read and write with data 0x33 -> write performed; finish[4] with data_out=0.
- Reset mid-operation: reset asserted in GRANT -> next cycle all outputs are 0, state IDLE, rr_ptr=0; requests still held after reset are granted normally.
